// File: rtl/dp_main_pkg.sv
// Shared constants, FSM state encoding and a saturating adder for the
// frame-level speech/silence decoder (dp_main).
package dp_main_pkg;

  // Default block parameters
  localparam int DEF_FRAME_LEN   = 256;
  localparam int DEF_SPEECH_COST = 512;
  localparam int DEF_TRANS_PEN   = 4096;
  localparam int DEF_DW          = 24;

  // Datapath widths
  localparam int SAMPLE_W = 16;  // signed PCM sample
  localparam int ABS_W    = 17;  // |sample|, holds 32768 (or up to 65535 with pre-emphasis)
  localparam int ENERGY_W = 16;  // per-frame mean absolute amplitude
  localparam int ACC_W    = 27;  // 1024 samples of 65535 fit with margin
  localparam int SAT_W    = 32;  // working width of sat_add (path cost width must stay below this)

  // Control FSM states
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_COST = 3'd1,
    ST_CMP  = 3'd2,
    ST_NORM = 3'd3,
    ST_OUT  = 3'd4
  } dp_state_e;

  // Unsigned add with one guard bit, clamped to 2^w - 1
  function automatic logic [SAT_W-1:0] sat_add(input logic [SAT_W-1:0] a,
                                               input logic [SAT_W-1:0] b,
                                               input int unsigned      w);
    logic [SAT_W:0] sum;
    logic [SAT_W:0] lim;
    sum = {1'b0, a} + {1'b0, b};
    lim = (33'd1 << w) - 33'd1;
    if (sum > lim) begin
      return lim[SAT_W-1:0];
    end else begin
      return sum[SAT_W-1:0];
    end
  endfunction

endpackage

// File: rtl/dp_frame_energy.sv
// Per-frame mean absolute amplitude: optional pre-emphasis, abs, accumulator
// and sample counter. Emits the energy snapshot and a one-cycle frame_done.
// Optional feature macro: DP_MAIN_PREEMPH_EN (first-order pre-emphasis).
module dp_frame_energy
  import dp_main_pkg::*;
#(
  parameter int FRAME_LEN = DEF_FRAME_LEN
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [SAMPLE_W-1:0] x,
  input  logic                write,
  output logic [ENERGY_W-1:0] e,
  output logic                frame_done
);

  localparam int CNT_W = $clog2(FRAME_LEN);

  logic [CNT_W-1:0]    cnt_r;
  logic [ACC_W-1:0]    acc_r;
  logic [ENERGY_W-1:0] e_r;
  logic                frame_done_r;

  logic [ABS_W-1:0]    a_s;
  logic [ACC_W-1:0]    sum_s;
  logic [ENERGY_W-1:0] e_next_s;
  logic                last_s;

`ifdef DP_MAIN_PREEMPH_EN
  logic signed [17:0]  x_ext_s;
  logic signed [17:0]  p_ext_s;
  logic signed [17:0]  y_s;
  logic [17:0]         y_u_s;
  logic [17:0]         y_abs_s;
  logic [SAMPLE_W-1:0] x_prev_r;

  // Pre-emphasis y = x - (x_prev - x_prev/32) at 18 bits, then abs clamped to 65535
  always_comb begin
    x_ext_s = {{2{x[15]}}, x};
    p_ext_s = {{2{x_prev_r[15]}}, x_prev_r};
    y_s     = x_ext_s - (p_ext_s - (p_ext_s >>> 5));
    y_u_s   = y_s;
    if (y_u_s[17]) begin
      y_abs_s = ~y_u_s + 18'd1;
    end else begin
      y_abs_s = y_u_s;
    end
    if (y_abs_s > 18'd65535) begin
      a_s = 17'd65535;
    end else begin
      a_s = y_abs_s[16:0];
    end
  end

  // Previous-sample register for the filter, advanced on every accepted sample
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_prev_r <= 16'd0;
    end else if (write) begin
      x_prev_r <= x;
    end else begin
      x_prev_r <= x_prev_r;
    end
  end
`else
  // Absolute value at 17 bits so that -32768 maps to 32768
  always_comb begin
    if (x[15]) begin
      a_s = ~{1'b1, x} + 17'd1;
    end else begin
      a_s = {1'b0, x};
    end
  end
`endif

  // Running sum including the current sample, its frame mean, and frame-end detect
  always_comb begin
    sum_s    = acc_r + {{(ACC_W-ABS_W){1'b0}}, a_s};
    e_next_s = ENERGY_W'(sum_s >> CNT_W);
    last_s   = (cnt_r == {CNT_W{1'b1}});
  end

  // Accumulate samples; on the last one snapshot the mean and restart the frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r        <= {CNT_W{1'b0}};
      acc_r        <= {ACC_W{1'b0}};
      e_r          <= {ENERGY_W{1'b0}};
      frame_done_r <= 1'b0;
    end else if (write) begin
      if (last_s) begin
        cnt_r        <= {CNT_W{1'b0}};
        acc_r        <= {ACC_W{1'b0}};
        e_r          <= e_next_s;
        frame_done_r <= 1'b1;
      end else begin
        cnt_r        <= cnt_r + CNT_W'(1);
        acc_r        <= sum_s;
        frame_done_r <= 1'b0;
      end
    end else begin
      frame_done_r <= 1'b0;
    end
  end

  assign e          = e_r;
  assign frame_done = frame_done_r;

endmodule

// File: rtl/dp_main.sv
// Two-state (silence/speech) Viterbi-style decoder over frame energies.
// One decision bit per frame on result, qualified by a result_dv pulse that
// follows the frame's last sample by five clocks.
// Optional feature macro: DP_MAIN_PREEMPH_EN (handled inside dp_frame_energy).
module dp_main
  import dp_main_pkg::*;
#(
  parameter int FRAME_LEN   = DEF_FRAME_LEN,
  parameter int SPEECH_COST = DEF_SPEECH_COST,
  parameter int TRANS_PEN   = DEF_TRANS_PEN,
  parameter int DW          = DEF_DW
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [SAMPLE_W-1:0] x_i,
  input  logic                write,
  output logic                result_dv,
  output logic                result
);

  localparam logic [2:0] IDLE = ST_IDLE;
  localparam logic [2:0] COST = ST_COST;
  localparam logic [2:0] CMP  = ST_CMP;
  localparam logic [2:0] NORM = ST_NORM;
  localparam logic [2:0] OUT  = ST_OUT;

  localparam logic [DW-1:0] TP_C = DW'(TRANS_PEN);
  localparam logic [DW-1:0] SC_C = DW'(SPEECH_COST);
  localparam int            PAD  = SAT_W - DW;

  logic [2:0]          state_r;
  logic [2:0]          state_nxt_s;
  logic [DW-1:0]       d0_r;        // stored silence path cost
  logic [DW-1:0]       d1_r;        // stored speech path cost
  logic [DW-1:0]       m0_r;        // best predecessor cost into silence
  logic [DW-1:0]       m1_r;        // best predecessor cost into speech
  logic [DW-1:0]       n0_r;
  logic [DW-1:0]       n1_r;
  logic                dec_r;
  logic                result_r;
  logic                result_dv_r;

  logic [ENERGY_W-1:0] e_s;
  logic                frame_done_s;
  logic [DW-1:0]       c01_s;       // silence -> speech candidate
  logic [DW-1:0]       c10_s;       // speech -> silence candidate
  logic [DW-1:0]       n0_s;
  logic [DW-1:0]       n1_s;
  logic [DW-1:0]       min_n_s;

  function automatic logic [SAT_W-1:0] widen(input logic [DW-1:0] v);
    return {{PAD{1'b0}}, v};
  endfunction

  dp_frame_energy #(
    .FRAME_LEN(FRAME_LEN)
  ) u_energy (
    .clk        (clk),
    .rst_n      (reset),
    .x          (x_i),
    .write      (write),
    .e          (e_s),
    .frame_done (frame_done_s)
  );

  // Saturating candidate and new-cost sums; tie on N0 == N1 keeps silence as minimum
  always_comb begin
    c10_s   = DW'(sat_add(widen(d1_r), widen(TP_C), DW));
    c01_s   = DW'(sat_add(widen(d0_r), widen(TP_C), DW));
    n0_s    = DW'(sat_add(widen(m0_r), {{(SAT_W-ENERGY_W){1'b0}}, e_s}, DW));
    n1_s    = DW'(sat_add(widen(m1_r), widen(SC_C), DW));
    min_n_s = dec_r ? n1_r : n0_r;
  end

  // Next-state logic: one pass COST->CMP->NORM->OUT per completed frame
  always_comb begin
    state_nxt_s = IDLE;
    case (state_r)
      IDLE:    state_nxt_s = frame_done_s ? COST : IDLE;
      COST:    state_nxt_s = CMP;
      CMP:     state_nxt_s = NORM;
      NORM:    state_nxt_s = OUT;
      OUT:     state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Recursion datapath: candidates, new costs and decision, normalization, output
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      d0_r        <= {DW{1'b0}};
      d1_r        <= TP_C;
      m0_r        <= {DW{1'b0}};
      m1_r        <= {DW{1'b0}};
      n0_r        <= {DW{1'b0}};
      n1_r        <= {DW{1'b0}};
      dec_r       <= 1'b0;
      result_r    <= 1'b0;
      result_dv_r <= 1'b0;
    end else begin
      result_dv_r <= 1'b0;
      case (state_r)
        COST: begin
          m0_r <= (d0_r < c10_s) ? d0_r : c10_s;
          m1_r <= (d1_r < c01_s) ? d1_r : c01_s;
        end
        CMP: begin
          n0_r  <= n0_s;
          n1_r  <= n1_s;
          dec_r <= (n1_s < n0_s);
        end
        NORM: begin
          d0_r <= n0_r - min_n_s;
          d1_r <= n1_r - min_n_s;
        end
        OUT: begin
          result_r    <= dec_r;
          result_dv_r <= 1'b1;
        end
        default: begin
          result_dv_r <= 1'b0;
        end
      endcase
    end
  end

  assign result    = result_r;
  assign result_dv = result_dv_r;

endmodule

// File: tb/tb_dp_main.sv
// Self-checking bench for dp_main: a driver pushes per-frame expectations
// (decision, stored costs, capture cycle) from an arithmetic model into a
// scoreboard; a monitor pops and compares on every result_dv pulse.
module tb_dp_main;

  localparam int FL = 256;
  localparam int SC = 512;
  localparam int TP = 4096;
  localparam int SAT_MAX = (1 << 24) - 1;

  logic        clk = 1'b0;
  logic        reset;
  logic        write;
  logic [15:0] x_i;
  logic        result_dv;
  logic        result;

  dp_main #(
    .FRAME_LEN(FL), .SPEECH_COST(SC), .TRANS_PEN(TP), .DW(24)
  ) dut (
    .clk(clk), .reset(reset), .x_i(x_i), .write(write),
    .result_dv(result_dv), .result(result)
  );

  always #10 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic res;
    int   d0;
    int   d1;
    int   cyc;
  } exp_t;

  exp_t sb[$];
  logic got[$];
  exp_t mon_t;

  int errors = 0;
  int checks = 0;
  int m_d0 = 0;
  int m_d1 = TP;
  int b_cnt = 0;
  int b_sum = 0;
  int max_cost = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  function automatic int min2(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic int sat(input int v);
    return (v > SAT_MAX) ? SAT_MAX : v;
  endfunction

  // Reference recursion on bench-held costs
  task automatic model(input int e, output logic r);
    int n0, n1, mn;
    n0 = sat(min2(m_d0, sat(m_d1 + TP)) + e);
    n1 = sat(min2(m_d1, sat(m_d0 + TP)) + SC);
    r  = (n1 < n0);
    mn = min2(n0, n1);
    m_d0 = n0 - mn;
    m_d1 = n1 - mn;
  endtask

  // Drive one sample (called on a falling edge), then idle 'gap' cycles
  task automatic send(input logic [15:0] x, input int gap);
    exp_t t;
    logic r;
    int   ax;
    write = 1'b1;
    x_i   = x;
    ax = x[15] ? (65536 - int'(x)) : int'(x);
    b_cnt++;
    b_sum += ax;
    if (b_cnt == FL) begin
      model(b_sum / FL, r);
      t.res = r;
      t.d0  = m_d0;
      t.d1  = m_d1;
      t.cyc = cyc + 1;
      sb.push_back(t);
      b_cnt = 0;
      b_sum = 0;
    end
    @(negedge clk);
    if (gap > 0) begin
      write = 1'b0;
      repeat (gap) @(negedge clk);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() > 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("drain_pending", sb.size(), 0);
  endtask

  // Monitor: compare each decision against the scoreboard; track peak stored cost
  always @(negedge clk) begin
    if (reset === 1'b1) begin
      if (result_dv === 1'b1) begin
        if (sb.size() == 0) begin
          chk("unexpected_dv", 1, 0);
        end else begin
          mon_t = sb.pop_front();
          chk("result", result, mon_t.res);
          chk("latency", cyc, mon_t.cyc + 5);
          chk("d0", dut.d0_r, mon_t.d0);
          chk("d1", dut.d1_r, mon_t.d1);
          got.push_back(result);
        end
      end
      if (int'(dut.d0_r) > max_cost) max_cost = int'(dut.d0_r);
      if (int'(dut.d1_r) > max_cost) max_cost = int'(dut.d1_r);
    end
  end

  initial begin
    int p;
    logic [15:0] rv;

    // Reset with write held high: samples during reset must be ignored
    reset = 1'b0;
    write = 1'b1;
    x_i   = 16'd5000;
    repeat (3) @(negedge clk);
    chk("rst_result", result, 0);
    chk("rst_dv", result_dv, 0);
    chk("rst_d0", dut.d0_r, 0);
    chk("rst_d1", dut.d1_r, TP);
    write = 1'b0;
    reset = 1'b1;
    @(negedge clk);

    // All-zero frames
    for (int i = 0; i < 4 * FL; i++) send(16'd0, 0);
    write = 1'b0;
    drain();

    // Constant 1000: silence for 8 frames, speech from frame 9
    p = got.size();
    for (int i = 0; i < 12 * FL; i++) send(16'd1000, 0);
    write = 1'b0;
    drain();
    chk("spd_frame1", got[p], 0);
    chk("spd_frame8", got[p + 7], 0);
    chk("spd_frame9", got[p + 8], 1);
    chk("spd_frame12", got[p + 11], 1);

    // Zeros after speech: decoder must return to silence
    p = got.size();
    for (int i = 0; i < 10 * FL; i++) send(16'd0, 0);
    write = 1'b0;
    drain();
    chk("sil_return", got[p + 9], 0);

    // Full-scale negative input: no overflow of stored costs
    max_cost = 0;
    for (int i = 0; i < 10 * FL; i++) send(16'h8000, 0);
    write = 1'b0;
    drain();
    chk("cost_bound", (max_cost <= 40960) ? 1 : 0, 1);

    // Sparse writes (every other clock) across a frame boundary, random samples
    for (int i = 0; i < 2 * FL; i++) begin
      rv = 16'($urandom_range(0, 65535));
      send(rv, 1);
    end
    write = 1'b0;
    drain();

    // Speech frame so result is 1, then reset after 100 samples of the next one
    for (int i = 0; i < FL; i++) send(16'h8000, 0);
    write = 1'b0;
    drain();
    for (int i = 0; i < 100; i++) send(16'd1000, 0);
    reset = 1'b0;
    #1;
    chk("midrst_result", result, 0);
    chk("midrst_dv", result_dv, 0);
    chk("midrst_d0", dut.d0_r, 0);
    chk("midrst_d1", dut.d1_r, TP);
    m_d0  = 0;
    m_d1  = TP;
    b_cnt = 0;
    b_sum = 0;
    sb.delete();
    repeat (2) @(negedge clk);
    write = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    p = got.size();
    for (int i = 0; i < FL; i++) send(16'd1000, 0);
    write = 1'b0;
    drain();
    chk("post_rst_frames", got.size(), p + 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
